// File: rtl/furv_pkg.sv
// Shared encodings for the furv RV32I pipeline: execute kinds, ALU operations
// and base-ISA opcodes.
package furv_pkg;

  typedef enum logic [3:0] {
    K_ALU     = 4'd0,
    K_ALUI    = 4'd1,
    K_LUI     = 4'd2,
    K_AUIPC   = 4'd3,
    K_JAL     = 4'd4,
    K_JALR    = 4'd5,
    K_BRANCH  = 4'd6,
    K_LOAD    = 4'd7,
    K_STORE   = 4'd8,
    K_ILLEGAL = 4'd9
  } kind_e;

  typedef enum logic [3:0] {
    A_ADD  = 4'd0,
    A_SUB  = 4'd1,
    A_SLL  = 4'd2,
    A_SLT  = 4'd3,
    A_SLTU = 4'd4,
    A_XOR  = 4'd5,
    A_SRL  = 4'd6,
    A_SRA  = 4'd7,
    A_OR   = 4'd8,
    A_AND  = 4'd9
  } aluop_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful
  function automatic aluop_e alu_from_f3(input logic [2:0] f3, input logic alt);
    aluop_e op;
    case (f3)
      3'b000:  op = alt ? A_SUB : A_ADD;
      3'b001:  op = A_SLL;
      3'b010:  op = A_SLT;
      3'b011:  op = A_SLTU;
      3'b100:  op = A_XOR;
      3'b101:  op = alt ? A_SRA : A_SRL;
      3'b110:  op = A_OR;
      default: op = A_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/furv_dec.sv
// Combinational RV32I decoder: classifies the instruction, extracts the immediate
// and reports which register fields are actually used.
module furv_dec
  import furv_pkg::*;
(
  input  logic [31:0] i_instr,
  output kind_e       o_kind,
  output aluop_e      o_aluop,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_use_rs1,
  output logic        o_use_rs2
);

  logic [6:0]  w_opcode;
  logic [6:0]  w_funct7;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic        w_has_rd;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

  always_comb begin
    o_kind    = K_ILLEGAL;
    o_aluop   = A_ADD;
    o_imm     = '0;
    w_has_rd  = 1'b0;
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    case (w_opcode)
      OP: begin
        if (w_funct7 == 7'h00 ||
            (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
          o_kind    = K_ALU;
          o_aluop   = alu_from_f3(w_funct3, w_funct7[5]);
          w_has_rd  = 1'b1;
          o_use_rs1 = 1'b1;
          o_use_rs2 = 1'b1;
        end
      end
      OP_IMM: begin
        // shift-immediates reuse the upper imm bits as funct7
        if ((w_funct3 != 3'b001 && w_funct3 != 3'b101) ||
            (w_funct3 == 3'b001 && w_funct7 == 7'h00) ||
            (w_funct3 == 3'b101 && (w_funct7 == 7'h00 || w_funct7 == 7'h20))) begin
          o_kind    = K_ALUI;
          o_aluop   = alu_from_f3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
          o_imm     = w_imm_i;
          w_has_rd  = 1'b1;
          o_use_rs1 = 1'b1;
        end
      end
      LUI: begin
        o_kind   = K_LUI;
        o_imm    = w_imm_u;
        w_has_rd = 1'b1;
      end
      AUIPC: begin
        o_kind   = K_AUIPC;
        o_imm    = w_imm_u;
        w_has_rd = 1'b1;
      end
      JAL: begin
        o_kind   = K_JAL;
        o_imm    = w_imm_j;
        w_has_rd = 1'b1;
      end
      JALR: begin
        if (w_funct3 == 3'b000) begin
          o_kind    = K_JALR;
          o_imm     = w_imm_i;
          w_has_rd  = 1'b1;
          o_use_rs1 = 1'b1;
        end
      end
      BRANCH: begin
        if (w_funct3 != 3'b010 && w_funct3 != 3'b011) begin
          o_kind    = K_BRANCH;
          o_imm     = w_imm_b;
          o_use_rs1 = 1'b1;
          o_use_rs2 = 1'b1;
        end
      end
      LOAD: begin
        if (w_funct3 != 3'b011 && w_funct3 != 3'b110 && w_funct3 != 3'b111) begin
          o_kind    = K_LOAD;
          o_imm     = w_imm_i;
          w_has_rd  = 1'b1;
          o_use_rs1 = 1'b1;
        end
      end
      STORE: begin
        if (w_funct3 == 3'b000 || w_funct3 == 3'b001 || w_funct3 == 3'b010) begin
          o_kind    = K_STORE;
          o_imm     = w_imm_s;
          o_use_rs1 = 1'b1;
          o_use_rs2 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_funct3 = w_funct3;
  assign o_rd     = w_has_rd  ? i_instr[11:7]  : 5'd0;
  assign o_rs1    = o_use_rs1 ? i_instr[19:15] : 5'd0;
  assign o_rs2    = o_use_rs2 ? i_instr[24:20] : 5'd0;

endmodule

// File: rtl/furv_de.sv
// furv decode/issue stage: one-entry fetch buffer, scoreboard-gated issue and the
// registered execute payload.
module furv_de
  import furv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        de_ready,
  output logic [4:0]  de_rs1_index,
  output logic [4:0]  de_rs2_index,
  output logic [4:0]  de_lock_rd,
  output logic        de_stall,
  input  logic [31:0] rf_rs1,
  input  logic [31:0] rf_rs2,
  input  logic        rf_rs1_ready,
  input  logic        rf_rs2_ready,
  output logic        ex_valid,
  input  logic        ex_ready,
  input  logic        ex_flush,
  output logic [3:0]  ex_kind,
  output logic [3:0]  ex_aluop,
  output logic [2:0]  ex_funct3,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_pc
);

  logic        r_buf_valid;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;

  logic        r_ex_valid;
  logic [3:0]  r_ex_kind;
  logic [3:0]  r_ex_aluop;
  logic [2:0]  r_ex_funct3;
  logic [31:0] r_ex_a;
  logic [31:0] r_ex_b;
  logic [31:0] r_ex_imm;
  logic [4:0]  r_ex_rd;
  logic [31:0] r_ex_pc;

  kind_e       w_kind;
  aluop_e      w_aluop;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_src1_ok;
  logic        w_src2_ok;
  logic        w_issue;
  logic        w_accept;

  furv_dec u_dec (
    .i_instr   (r_buf_instr),
    .o_kind    (w_kind),
    .o_aluop   (w_aluop),
    .o_funct3  (w_funct3),
    .o_imm     (w_imm),
    .o_rd      (w_rd),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  // x0 and unused sources never block issue
  assign w_src1_ok = !w_use_rs1 || (w_rs1 == 5'd0) || rf_rs1_ready;
  assign w_src2_ok = !w_use_rs2 || (w_rs2 == 5'd0) || rf_rs2_ready;

  assign w_issue  = r_buf_valid && w_src1_ok && w_src2_ok && (!r_ex_valid || ex_ready) && !ex_flush;
  assign de_ready = !r_buf_valid || w_issue;
  assign w_accept = if_valid && de_ready && !ex_flush;

  assign de_stall     = !w_issue;
  assign de_lock_rd   = w_issue ? w_rd : 5'd0;
  assign de_rs1_index = r_buf_valid ? w_rs1 : 5'd0;
  assign de_rs2_index = r_buf_valid ? w_rs2 : 5'd0;

  // Fetch buffer: control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
    end else if (ex_flush) begin
      r_buf_valid <= 1'b0;
    end else if (w_accept) begin
      r_buf_valid <= 1'b1;
    end else if (w_issue) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Fetch buffer: data, qualified by r_buf_valid
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_instr <= if_instr;
      r_buf_pc    <= if_pc;
    end
  end

  // Execute payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_kind   <= '0;
      r_ex_aluop  <= '0;
      r_ex_funct3 <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_ex_imm    <= '0;
      r_ex_rd     <= '0;
      r_ex_pc     <= '0;
    end else if (ex_flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_issue) begin
      r_ex_valid  <= 1'b1;
      r_ex_kind   <= w_kind;
      r_ex_aluop  <= w_aluop;
      r_ex_funct3 <= w_funct3;
      r_ex_a      <= rf_rs1;
      r_ex_b      <= rf_rs2;
      r_ex_imm    <= w_imm;
      r_ex_rd     <= w_rd;
      r_ex_pc     <= r_buf_pc;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_kind   = r_ex_kind;
  assign ex_aluop  = r_ex_aluop;
  assign ex_funct3 = r_ex_funct3;
  assign ex_a      = r_ex_a;
  assign ex_b      = r_ex_b;
  assign ex_imm    = r_ex_imm;
  assign ex_rd     = r_ex_rd;
  assign ex_pc     = r_ex_pc;

endmodule

// File: tb/tb_furv_de.sv
// Bench for furv_de: directed scenarios, then randomized RV32I traffic against an
// in-order architectural model with a locking register-file environment.
module tb_furv_de;
  import furv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        de_ready;
  logic [4:0]  de_rs1_index, de_rs2_index, de_lock_rd;
  logic        de_stall;
  logic [31:0] rf_rs1, rf_rs2;
  logic        rf_rs1_ready, rf_rs2_ready;
  logic        ex_valid, ex_ready, ex_flush;
  logic [3:0]  ex_kind, ex_aluop;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  furv_de dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .de_ready(de_ready), .de_rs1_index(de_rs1_index), .de_rs2_index(de_rs2_index),
    .de_lock_rd(de_lock_rd), .de_stall(de_stall), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_ready(rf_rs1_ready), .rf_rs2_ready(rf_rs2_ready), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_kind(ex_kind), .ex_aluop(ex_aluop),
    .ex_funct3(ex_funct3), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_pc(ex_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- register-file environment ----------------
  logic        env_on = 1'b0;
  logic [31:0] man_rs1 = '0, man_rs2 = '0;
  logic        man_r1 = 1'b1, man_r2 = 1'b1;

  typedef struct packed { logic [4:0] rd; logic [31:0] v; } wb_t;
  wb_t         wbq[$];
  wb_t         wb_h;
  int          lockc [32];
  logic [31:0] rv    [32];
  logic [31:0] rfq   [32];
  logic [31:0] rdyq;

  function automatic logic [31:0] wbval(input logic [31:0] pc);
    return pc * 32'h9E3779B1 + 32'd1;
  endfunction

  always @(posedge clk) begin
    if (!env_on) begin
      wbq.delete();
      for (int i = 0; i < 32; i++) begin
        lockc[i] = 0;
        rv[i]    = '0;
        rfq[i]  <= '0;
      end
      rdyq <= '1;
    end else begin
      if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_h = wbq.pop_front();
        rv[wb_h.rd] = wb_h.v;
        if (lockc[wb_h.rd] > 0) lockc[wb_h.rd]--;
      end
      if (ex_valid && ex_ready && ex_rd != 5'd0) wbq.push_back('{ex_rd, wbval(ex_pc)});
      if (de_lock_rd != 5'd0) lockc[de_lock_rd]++;
      for (int i = 0; i < 32; i++) begin
        rfq[i]  <= rv[i];
        rdyq[i] <= (lockc[i] == 0);
      end
    end
  end

  assign rf_rs1       = env_on ? rfq[de_rs1_index]  : man_rs1;
  assign rf_rs2       = env_on ? rfq[de_rs2_index]  : man_rs2;
  assign rf_rs1_ready = env_on ? rdyq[de_rs1_index] : man_r1;
  assign rf_rs2_ready = env_on ? rdyq[de_rs2_index] : man_r2;

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [3:0]  kind;
    logic [3:0]  aluop;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] a, b, pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e, m_e;
  logic [4:0]  cur_s1, cur_s2;
  logic [31:0] arch [32];

  function automatic logic [2:0] r_f3(input int op);
    case (op)
      0, 1:    return 3'd0;
      2:       return 3'd1;
      3:       return 3'd2;
      4:       return 3'd3;
      5:       return 3'd4;
      6, 7:    return 3'd5;
      8:       return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic gen(input logic [31:0] pc, output logic [31:0] ins, output exp_t e,
                     output logic [4:0] s1, output logic [4:0] s2);
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [20:0] j21;
    logic [12:0] b13;
    int          op, k;
    rd  = 5'($urandom_range(0, 7));
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    i12 = 12'($urandom);
    u20 = 20'($urandom);
    j21 = {20'($urandom), 1'b0};
    b13 = {12'($urandom), 1'b0};
    e = '{default: '0};
    e.pc = pc;
    s1 = 5'd0;
    s2 = 5'd0;
    case ($urandom_range(0, 10))
      0: begin
        op = $urandom_range(0, 9);
        ins = {(op == 1 || op == 7) ? 7'h20 : 7'h00, r2, r1, r_f3(op), rd, 7'b0110011};
        e.kind = K_ALU; e.aluop = 4'(op); e.rd = rd; s1 = r1; s2 = r2;
      end
      1: begin
        op = $urandom_range(0, 8);
        if (op >= 1) op++;
        if (op == 2 || op == 6 || op == 7) i12 = {(op == 7) ? 7'h20 : 7'h00, 5'($urandom)};
        ins = {i12, r1, r_f3(op), rd, 7'b0010011};
        e.kind = K_ALUI; e.aluop = 4'(op); e.rd = rd; s1 = r1;
        e.imm = {{20{i12[11]}}, i12};
      end
      2: begin
        ins = {u20, rd, 7'b0110111};
        e.kind = K_LUI; e.rd = rd; e.imm = {u20, 12'b0};
      end
      3: begin
        ins = {u20, rd, 7'b0010111};
        e.kind = K_AUIPC; e.rd = rd; e.imm = {u20, 12'b0};
      end
      4: begin
        ins = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'b1101111};
        e.kind = K_JAL; e.rd = rd; e.imm = {{11{j21[20]}}, j21};
      end
      5: begin
        ins = {i12, r1, 3'b000, rd, 7'b1100111};
        e.kind = K_JALR; e.rd = rd; s1 = r1; e.imm = {{20{i12[11]}}, i12};
      end
      6: begin
        k = $urandom_range(0, 5);
        f3 = (k < 2) ? 3'(k) : 3'(k + 2);
        ins = {b13[12], b13[10:5], r2, r1, f3, b13[4:1], b13[11], 7'b1100011};
        e.kind = K_BRANCH; s1 = r1; s2 = r2; e.imm = {{19{b13[12]}}, b13};
      end
      7: begin
        k = $urandom_range(0, 4);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
        ins = {i12, r1, f3, rd, 7'b0000011};
        e.kind = K_LOAD; e.rd = rd; s1 = r1; e.imm = {{20{i12[11]}}, i12};
      end
      8: begin
        f3 = 3'($urandom_range(0, 2));
        ins = {i12[11:5], r2, r1, f3, i12[4:0], 7'b0100011};
        e.kind = K_STORE; s1 = r1; s2 = r2; e.imm = {{20{i12[11]}}, i12};
      end
      default: begin
        case ($urandom_range(0, 2))
          0:       ins = {25'($urandom), 7'h7F};
          1:       ins = {7'h01, r2, r1, 3'($urandom), rd, 7'b0110011};
          default: ins = {i12, r1, 3'b011, rd, 7'b1100111};
        endcase
        e.kind = K_ILLEGAL;
      end
    endcase
    e.f3 = ins[14:12];
  endtask

  // Monitor: every payload consumed by execute must match the oldest expectation
  always @(negedge clk) begin
    if (env_on && !rst && ex_valid && ex_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        m_e = exp_q.pop_front();
        chk("pc", ex_pc, m_e.pc);
        chk("kind", 32'(ex_kind), 32'(m_e.kind));
        chk("rd", 32'(ex_rd), 32'(m_e.rd));
        chk("funct3", 32'(ex_funct3), 32'(m_e.f3));
        if (m_e.kind == K_ALU || m_e.kind == K_ALUI) chk("aluop", 32'(ex_aluop), 32'(m_e.aluop));
        if (m_e.kind != K_ILLEGAL) begin
          chk("imm", ex_imm, m_e.imm);
          chk("a", ex_a, m_e.a);
          chk("b", ex_b, m_e.b);
        end
      end
    end
  end

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc_n;
    logic [31:0] ins;
    logic        have;
    int          n_acc;
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b1; ex_flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {de_ready, de_stall, de_lock_rd, ex_valid}, {1'b1, 1'b1, 5'd0, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    chk("reset_payload", {ex_valid, ex_kind, ex_rd}, '0);
    chk("reset_imm", ex_imm, '0);

    // addi x1,x0,5
    offer(32'h00500093, 32'h0);
    @(negedge clk);
    if_valid = 1'b0;
    chk("addi_lock", 32'(de_lock_rd), 32'd1);
    chk("addi_issue", {de_stall, ex_valid}, 2'b00);
    @(negedge clk);
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_kind", 32'(ex_kind), 32'(K_ALUI));
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_rd", 32'(ex_rd), 32'd1);
    chk("addi_lock_once", 32'(de_lock_rd), 32'd0);
    @(negedge clk);
    chk("addi_consumed", 32'(ex_valid), 32'd0);

    // add x3,x1,x2 with x2 locked for 4 cycles
    man_rs1 = 32'h12345678; man_rs2 = 32'h00001111; man_r2 = 1'b0;
    offer(32'h002081B3, 32'h4);
    @(negedge clk);
    if_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("raw_stall", {de_stall, de_lock_rd, de_ready, de_rs2_index}, {1'b1, 5'd0, 1'b0, 5'd2});
      @(negedge clk);
    end
    man_r2 = 1'b1; man_rs2 = 32'hCAFE0002;
    #1;
    chk("raw_release", {de_stall, de_lock_rd}, {1'b0, 5'd3});
    @(negedge clk);
    chk("raw_b", ex_b, 32'hCAFE0002);
    chk("raw_a", ex_a, 32'h12345678);
    chk("raw_kind", {ex_valid, ex_kind, ex_aluop}, {1'b1, K_ALU, A_ADD});

    // execute backpressure with two instructions queued
    @(negedge clk);
    ex_ready = 1'b0;
    offer(32'h00100213, 32'h100);
    @(negedge clk);
    offer(32'h00200293, 32'h104);
    @(negedge clk);
    if_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold", {ex_valid, ex_rd, de_ready}, {1'b1, 5'd4, 1'b0});
      chk("bp_hold_pc", ex_pc, 32'h100);
      if (k == 2) ex_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_second", {ex_valid, ex_rd}, {1'b1, 5'd5});
    chk("bp_second_pc", ex_pc, 32'h104);
    @(negedge clk);
    chk("bp_no_dup", 32'(ex_valid), 32'd0);

    // sw x2,8(x1) then beq x0,x0,-4
    offer(32'h0020A423, 32'h200);
    @(negedge clk);
    offer(32'hFE000EE3, 32'h204);
    chk("sw_no_lock", {de_stall, de_lock_rd}, '0);
    @(negedge clk);
    if_valid = 1'b0;
    chk("sw_fields", {ex_kind, ex_rd}, {K_STORE, 5'd0});
    chk("sw_imm", ex_imm, 32'd8);
    @(negedge clk);
    chk("beq_kind", 32'(ex_kind), 32'(K_BRANCH));
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);

    // flush with payload, buffer and fetch all occupied
    @(negedge clk);
    ex_ready = 1'b0;
    offer(32'h00600313, 32'h300);
    @(negedge clk);
    offer(32'h00700393, 32'h304);
    @(negedge clk);
    offer(32'h00100213, 32'h308);
    ex_flush = 1'b1;
    #1;
    chk("flush_no_issue", {ex_valid, de_stall, de_lock_rd, de_ready}, {1'b1, 1'b1, 5'd0, 1'b0});
    @(negedge clk);
    ex_flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    chk("flush_cleared", {ex_valid, de_ready, de_stall}, {1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("flush_fetch_dropped", {ex_valid, de_stall}, {1'b0, 1'b1});

    // illegal opcode, then reset while a RAW stall is pending
    ex_ready = 1'b0;
    offer(32'h0000007F, 32'h400);
    @(negedge clk);
    man_r2 = 1'b0;
    offer(32'h002081B3, 32'h404);
    chk("ill_no_lock", {de_stall, de_lock_rd}, '0);
    @(negedge clk);
    if_valid = 1'b0;
    chk("ill_fields", {ex_valid, ex_kind, ex_rd}, {1'b1, K_ILLEGAL, 5'd0});
    @(negedge clk);
    chk("pre_rst_stall", {de_stall, de_ready}, {1'b1, 1'b0});
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {de_ready, de_stall, de_lock_rd, ex_valid}, {1'b1, 1'b1, 5'd0, 1'b0});
    chk("mid_rst_payload", {ex_kind, ex_aluop, ex_funct3, ex_rd}, '0);
    chk("mid_rst_pc", ex_pc, '0);
    @(negedge clk);
    rst = 1'b0; man_r2 = 1'b1;

    // randomized traffic
    for (int i = 0; i < 32; i++) arch[i] = '0;
    exp_q.delete();
    env_on = 1'b1;
    have = 1'b0; n_acc = 0; pc_n = 32'h1000;
    for (int cyc = 0; cyc < 30000 && n_acc < 1500; cyc++) begin
      @(negedge clk);
      if (if_valid && de_ready) begin
        cur_e.a = arch[cur_s1];
        cur_e.b = arch[cur_s2];
        exp_q.push_back(cur_e);
        if (cur_e.rd != 5'd0) arch[cur_e.rd] = wbval(cur_e.pc);
        arch[0] = '0;
        n_acc++;
        have = 1'b0;
      end
      @(posedge clk);
      #1;
      ex_ready = ($urandom_range(0, 3) != 0);
      if (!have && $urandom_range(0, 4) != 0) begin
        gen(pc_n, ins, cur_e, cur_s1, cur_s2);
        if_instr = ins;
        if_pc    = pc_n;
        pc_n     = pc_n + 32'd4;
        have     = 1'b1;
      end
      if_valid = have;
    end
    if_valid = 1'b0;
    ex_ready = 1'b1;
    chk("random_accepted", 32'(n_acc), 32'd1500);
    repeat (300) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
